data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the core load/store path (port 0) and the DMA/debug loader (port 1). It sits directly in front of the data memory. Each cycle it grants at most one requester and drives the memory's write enable, read enable, address and write-data inputs. Read data is captured into a per-port response register. Port 0 has priority, and a saturating starvation counter guarantees forward progress for port 1.

---
 rtl/data_mem_arb_pkg.sv | 20 ++
 rtl/arb_starve_counter.sv | 29 ++
 rtl/data_mem_arbiter.sv | 112 +++++++++++
 tb/tb_data_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package data_mem_arb_pkg;

  localparam int ARB_ADDR_WIDTH       = 32;
  localparam int ARB_DATA_WIDTH       = 16;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef struct packed {
    logic                      wr;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_P0   = 2'd1,
    SEL_P1   = 2'd2
  } port_sel_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles port 1 has waited without a grant.
module arb_starve_counter
  import data_mem_arb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT_V)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign at_limit = (r_cnt == LIMIT_V);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: port 0 has
// priority, port 1 is guaranteed a grant once it has waited STARVE_LIMIT cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_access_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  port_sel_e             w_sel;
  req_t                  w_win;
  logic                  w_at_limit;
  logic                  w_p0_gnt;
  logic                  w_p1_gnt;
  logic                  r_p0_rvalid;
  logic                  r_p1_rvalid;
  logic [DATA_WIDTH-1:0] r_p0_rdata;
  logic [DATA_WIDTH-1:0] r_p1_rdata;

  // Reset suppresses every grant so no memory command can issue during reset.
  always_comb begin
    w_sel = SEL_NONE;
    if (!rst_in) begin
      if (p1_req && w_at_limit) begin
        w_sel = SEL_P1;
      end else if (p0_req) begin
        w_sel = SEL_P0;
      end else if (p1_req) begin
        w_sel = SEL_P1;
      end
    end
  end

  assign w_p0_gnt = (w_sel == SEL_P0);
  assign w_p1_gnt = (w_sel == SEL_P1);
  assign p0_gnt   = w_p0_gnt;
  assign p1_gnt   = w_p1_gnt;

  always_comb begin
    w_win = '0;
    case (w_sel)
      SEL_P0:  w_win = '{wr: p0_wr, addr: p0_addr, wdata: p0_wdata};
      SEL_P1:  w_win = '{wr: p1_wr, addr: p1_addr, wdata: p1_wdata};
      default: w_win = '0;
    endcase
  end

  assign mem_wr_en       = (w_sel != SEL_NONE) &&  w_win.wr;
  assign mem_rd_en       = (w_sel != SEL_NONE) && !w_win.wr;
  assign mem_access_addr = w_win.addr;
  assign mem_data_in     = w_win.wdata;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .inc     (p1_req && !w_p1_gnt),
    .clr     (!p1_req || w_p1_gnt),
    .at_limit(w_at_limit)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= w_p0_gnt && !p0_wr;
      r_p1_rvalid <= w_p1_gnt && !p1_wr;
      if (w_p0_gnt && !p0_wr) r_p0_rdata <= mem_data_out;
      if (w_p1_gnt && !p1_wr) r_p1_rdata <= mem_data_out;
    end
  end

  // A response registered just before reset rises must not be seen as valid.
  assign p0_rvalid = r_p0_rvalid && !rst_in;
  assign p1_rvalid = r_p1_rvalid && !rst_in;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed checks of the data-memory arbiter against a halfword-indexed memory model.
module tb_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          p0_req, p0_wr, p1_req, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_access_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] mem [0:65535];
  logic [15:0]   w_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  assign w_idx        = mem_access_addr[AW/2:1];
  assign mem_data_out = mem[w_idx];

  always @(posedge clk_in) begin
    if (mem_wr_en) mem[w_idx] <= mem_data_in;
  end

  data_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .p0_req         (p0_req),
    .p0_wr          (p0_wr),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_gnt         (p0_gnt),
    .p0_rvalid      (p0_rvalid),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_wr          (p1_wr),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_gnt         (p1_gnt),
    .p1_rvalid      (p1_rvalid),
    .p1_rdata       (p1_rdata),
    .mem_wr_en      (mem_wr_en),
    .mem_rd_en      (mem_rd_en),
    .mem_access_addr(mem_access_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic test_reset();
    rst_in = 1;
    p0_req = 1; p0_wr = 1; p0_addr = 32'h10; p0_wdata = 16'h1234;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h20;
    tick(); tick();
    #1;
    n_cmp++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_p0_gnt: got %b want 0", p0_gnt); end
    n_cmp++; if (p1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_p1_gnt: got %b want 0", p1_gnt); end
    n_cmp++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b want 00", {mem_wr_en, mem_rd_en}); end
    n_cmp++; if (mem_access_addr !== 32'h0 || mem_data_in !== 16'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h data %h want 0 0", mem_access_addr, mem_data_in); end
    n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {p0_rvalid, p1_rvalid}); end
    n_cmp++; if (p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0000 0000", p0_rdata, p1_rdata); end
    idle_inputs();
    rst_in = 0;
    tick();
  endtask

  task automatic test_p0_only();
    p0_req = 1; p0_wr = 1; p0_addr = 32'h0004; p0_wdata = 16'hBEEF;
    #1;
    n_cmp++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL p0_wr_gnt: got %b want 1", p0_gnt); end
    n_cmp++; if ({mem_wr_en, mem_rd_en} !== 2'b10) begin n_fail++; $display("FAIL p0_wr_en: got %b want 10", {mem_wr_en, mem_rd_en}); end
    n_cmp++; if (mem_access_addr !== 32'h4 || mem_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL p0_wr_bus: got %h %h want 00000004 beef", mem_access_addr, mem_data_in); end
    tick();
    n_cmp++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL p0_wr_no_rvalid: got %b want 0", p0_rvalid); end
    p0_wr = 0; p0_wdata = '0;
    #1;
    n_cmp++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL p0_rd_gnt: got %b want 1", p0_gnt); end
    n_cmp++; if ({mem_wr_en, mem_rd_en} !== 2'b01) begin n_fail++; $display("FAIL p0_rd_en: got %b want 01", {mem_wr_en, mem_rd_en}); end
    tick();
    p0_req = 0;
    n_cmp++; if (p0_rvalid !== 1'b1) begin n_fail++; $display("FAIL p0_rd_rvalid: got %b want 1", p0_rvalid); end
    n_cmp++; if (p0_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL p0_rd_rdata: got %h want beef", p0_rdata); end
    tick();
    n_cmp++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL p0_rvalid_pulse: got %b want 0", p0_rvalid); end
    n_cmp++; if (p0_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL p0_rdata_hold: got %h want beef", p0_rdata); end
  endtask

  task automatic test_starvation();
    p0_req = 1; p0_wr = 0; p0_addr = 32'h10;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h20;
    for (int i = 1; i <= 10; i++) begin
      logic exp_p1;
      exp_p1 = (i == 5) || (i == 10);
      #1;
      n_cmp++;
      if (p0_gnt !== !exp_p1 || p1_gnt !== exp_p1) begin
        n_fail++;
        $display("FAIL starve_cycle%0d: got p0_gnt %b p1_gnt %b want %b %b", i, p0_gnt, p1_gnt, !exp_p1, exp_p1);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_isolation();
    p0_req = 1; p0_wr = 1; p0_addr = 32'h0002; p0_wdata = 16'h1111;
    tick();
    p0_wr = 0; p0_wdata = '0;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h0002;
    #1;
    n_cmp++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL iso_gnt_a: got %b%b want 10", p0_gnt, p1_gnt); end
    tick();
    p0_req = 0;
    #1;
    n_cmp++; if (p1_gnt !== 1'b1) begin n_fail++; $display("FAIL iso_p1_gnt: got %b want 1", p1_gnt); end
    n_cmp++; if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL iso_rvalid_a: got %b%b want 10", p0_rvalid, p1_rvalid); end
    n_cmp++; if (p0_rdata !== 16'h1111) begin n_fail++; $display("FAIL iso_p0_rdata: got %h want 1111", p0_rdata); end
    tick();
    p1_req = 0;
    n_cmp++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b1) begin n_fail++; $display("FAIL iso_rvalid_b: got %b%b want 01", p0_rvalid, p1_rvalid); end
    n_cmp++; if (p1_rdata !== 16'h1111 || p0_rdata !== 16'h1111) begin n_fail++; $display("FAIL iso_rdata_b: got p0 %h p1 %h want 1111 1111", p0_rdata, p1_rdata); end
    tick();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_access_addr !== 32'h0 || mem_data_in !== 16'h0 ||
          p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_%0d: got wr %b rd %b addr %h din %h rv %b%b gnt %b%b want all zero", i,
                 mem_wr_en, mem_rd_en, mem_access_addr, mem_data_in, p0_rvalid, p1_rvalid, p0_gnt, p1_gnt);
      end
    end
  endtask

  task automatic test_write_then_read();
    p1_req = 1; p1_wr = 1; p1_addr = 32'h00A0; p1_wdata = 16'h5A5A;
    #1;
    n_cmp++; if (p1_gnt !== 1'b1 || mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL wtr_p1_wr: got gnt %b wr_en %b want 1 1", p1_gnt, mem_wr_en); end
    tick();
    p1_req = 0; p1_wr = 0; p1_wdata = '0;
    p0_req = 1; p0_wr = 0; p0_addr = 32'h00A0;
    #1;
    n_cmp++; if (p0_gnt !== 1'b1 || mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL wtr_p0_rd: got gnt %b rd_en %b want 1 1", p0_gnt, mem_rd_en); end
    n_cmp++; if (p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wtr_p1_no_rvalid: got %b want 0", p1_rvalid); end
    tick();
    p0_req = 0;
    n_cmp++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL wtr_p0_rdata: got rv %b data %h want 1 5a5a", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    p1_req = 1; p1_wr = 0; p1_addr = 32'h0004;
    #1;
    n_cmp++; if (p1_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt: got %b want 1", p1_gnt); end
    tick();
    rst_in = 1;
    p1_req = 0;
    #1;
    n_cmp++; if (p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_rvalid_t1: got %b want 0", p1_rvalid); end
    tick();
    n_cmp++; if (p1_rvalid !== 1'b0 || p1_rdata !== 16'h0) begin n_fail++; $display("FAIL rmr_t2: got rv %b data %h want 0 0000", p1_rvalid, p1_rdata); end
    rst_in = 0;
    tick();
    // Starvation count restarts from zero: p1 must wait exactly four cycles.
    p0_req = 1; p0_wr = 0; p0_addr = 32'h30;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h40;
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_cmp++;
      if (p1_gnt !== (i == 5) || p0_gnt !== (i != 5)) begin
        n_fail++;
        $display("FAIL rmr_cnt_cycle%0d: got p0_gnt %b p1_gnt %b want %b %b", i, p0_gnt, p1_gnt, (i != 5), (i == 5));
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_in = 1;
    test_reset();
    test_p0_only();
    test_starvation();
    test_isolation();
    test_idle();
    test_write_then_read();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
